dpe_demultiplexer: RTL and testbench

Packet-level router at the egress of the data-plane engine (DPE). It accepts the single 128-bit DPE AXI-Stream and steers each whole packet to one of five outputs (CPU, ETH_1..ETH_4) according to `tuser_dst`, which is sampled on the packet's first beat. Packets with an unknown destination are dropped and counted. Each output has its own skid register, so one stalled port blocks only the input stream, never another port's beats already in flight.

---
 rtl/dpe_demultiplexer.sv | 228 ++++++++++++++++++++++
 tb/tb_dpe_demultiplexer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpe_demultiplexer.sv
// Packet router at the DPE egress: steers whole AXI-Stream packets to CPU or ETH_1..4 by the
// destination sampled on the first beat, drops unknown destinations, and buffers each port in a 2-entry skid.
module dpe_demultiplexer #(
    parameter int DATA_WIDTH = 128,
    parameter int DROP_CNT_W = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    pause,
    output logic                    is_idle,
    output logic [DROP_CNT_W-1:0]   drop_cnt,

    input  logic [DATA_WIDTH-1:0]   from_dpe_tdata,
    input  logic [DATA_WIDTH/8-1:0] from_dpe_tkeep,
    input  logic                    from_dpe_tlast,
    input  logic                    from_dpe_tuser_bypass_all,
    input  logic                    from_dpe_tuser_bypass_stage,
    input  logic [2:0]              from_dpe_tuser_src,
    input  logic [2:0]              from_dpe_tuser_dst,
    input  logic                    from_dpe_tvalid,
    output logic                    from_dpe_tready,

    output logic [DATA_WIDTH-1:0]   to_cpu_tdata,
    output logic [DATA_WIDTH/8-1:0] to_cpu_tkeep,
    output logic                    to_cpu_tlast,
    output logic                    to_cpu_tuser_bypass_all,
    output logic                    to_cpu_tuser_bypass_stage,
    output logic [2:0]              to_cpu_tuser_src,
    output logic [2:0]              to_cpu_tuser_dst,
    output logic                    to_cpu_tvalid,
    input  logic                    to_cpu_tready,

    output logic [DATA_WIDTH-1:0]   to_eth_1_tdata,
    output logic [DATA_WIDTH/8-1:0] to_eth_1_tkeep,
    output logic                    to_eth_1_tlast,
    output logic                    to_eth_1_tuser_bypass_all,
    output logic                    to_eth_1_tuser_bypass_stage,
    output logic [2:0]              to_eth_1_tuser_src,
    output logic [2:0]              to_eth_1_tuser_dst,
    output logic                    to_eth_1_tvalid,
    input  logic                    to_eth_1_tready,

    output logic [DATA_WIDTH-1:0]   to_eth_2_tdata,
    output logic [DATA_WIDTH/8-1:0] to_eth_2_tkeep,
    output logic                    to_eth_2_tlast,
    output logic                    to_eth_2_tuser_bypass_all,
    output logic                    to_eth_2_tuser_bypass_stage,
    output logic [2:0]              to_eth_2_tuser_src,
    output logic [2:0]              to_eth_2_tuser_dst,
    output logic                    to_eth_2_tvalid,
    input  logic                    to_eth_2_tready,

    output logic [DATA_WIDTH-1:0]   to_eth_3_tdata,
    output logic [DATA_WIDTH/8-1:0] to_eth_3_tkeep,
    output logic                    to_eth_3_tlast,
    output logic                    to_eth_3_tuser_bypass_all,
    output logic                    to_eth_3_tuser_bypass_stage,
    output logic [2:0]              to_eth_3_tuser_src,
    output logic [2:0]              to_eth_3_tuser_dst,
    output logic                    to_eth_3_tvalid,
    input  logic                    to_eth_3_tready,

    output logic [DATA_WIDTH-1:0]   to_eth_4_tdata,
    output logic [DATA_WIDTH/8-1:0] to_eth_4_tkeep,
    output logic                    to_eth_4_tlast,
    output logic                    to_eth_4_tuser_bypass_all,
    output logic                    to_eth_4_tuser_bypass_stage,
    output logic [2:0]              to_eth_4_tuser_src,
    output logic [2:0]              to_eth_4_tuser_dst,
    output logic                    to_eth_4_tvalid,
    input  logic                    to_eth_4_tready
);

    localparam int NPORT = 5;
    localparam int PW    = DATA_WIDTH + DATA_WIDTH/8 + 9;

    localparam logic [2:0] DPE_ADDR_CPU   = 3'd0;
    localparam logic [2:0] DPE_ADDR_ETH_1 = 3'd1;
    localparam logic [2:0] DPE_ADDR_ETH_2 = 3'd2;
    localparam logic [2:0] DPE_ADDR_ETH_3 = 3'd3;
    localparam logic [2:0] DPE_ADDR_ETH_4 = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_SOP, ST_FWD, ST_DROP} state_t;

    state_t             state_q, state_d;
    logic [NPORT-1:0]   port_q, port_d;
    logic [NPORT-1:0]   dec_oh;
    logic               dec_valid;
    logic [NPORT-1:0]   push;
    logic [NPORT-1:0]   port_ready;
    logic [NPORT-1:0]   m_valid;
    logic [NPORT-1:0]   m_tready;
    logic [PW-1:0]      m_payload [NPORT];
    logic [PW-1:0]      in_payload;
    logic               drop_inc;

    assign in_payload = {from_dpe_tdata, from_dpe_tkeep, from_dpe_tlast, from_dpe_tuser_bypass_all,
                         from_dpe_tuser_bypass_stage, from_dpe_tuser_src, from_dpe_tuser_dst};
    assign m_tready   = {to_eth_4_tready, to_eth_3_tready, to_eth_2_tready, to_eth_1_tready, to_cpu_tready};

    always_comb begin
        dec_oh = '0;
        case (from_dpe_tuser_dst)
            DPE_ADDR_CPU:   dec_oh = 5'b00001;
            DPE_ADDR_ETH_1: dec_oh = 5'b00010;
            DPE_ADDR_ETH_2: dec_oh = 5'b00100;
            DPE_ADDR_ETH_3: dec_oh = 5'b01000;
            DPE_ADDR_ETH_4: dec_oh = 5'b10000;
            default:        dec_oh = '0;
        endcase
    end
    assign dec_valid = |dec_oh;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            port_q   <= '0;
            drop_cnt <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            if (drop_inc && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // A single-beat packet to an unknown destination is counted straight from SOP.
    always_comb begin
        state_d         = state_q;
        port_d          = port_q;
        from_dpe_tready = 1'b0;
        push            = '0;
        drop_inc        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!pause)
                    state_d = ST_SOP;
            end
            ST_SOP: begin
                from_dpe_tready = dec_valid ? |(dec_oh & port_ready) : 1'b1;
                if (from_dpe_tvalid && from_dpe_tready) begin
                    port_d = dec_oh;
                    push   = dec_oh;
                    if (from_dpe_tlast) begin
                        drop_inc = !dec_valid;
                        state_d  = pause ? ST_IDLE : ST_SOP;
                    end else begin
                        state_d  = dec_valid ? ST_FWD : ST_DROP;
                    end
                end else if (pause) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD: begin
                from_dpe_tready = |(port_q & port_ready);
                if (from_dpe_tvalid && from_dpe_tready) begin
                    push = port_q;
                    if (from_dpe_tlast)
                        state_d = pause ? ST_IDLE : ST_SOP;
                end
            end
            ST_DROP: begin
                from_dpe_tready = 1'b1;
                if (from_dpe_tvalid && from_dpe_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = pause ? ST_IDLE : ST_SOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // slot0 always holds the head beat; slot1 only fills when the port stalls with one beat waiting.
    for (genvar p = 0; p < NPORT; p++) begin : g_skid
        logic [PW-1:0] slot0, slot1;
        logic [1:0]    occ;
        logic          rdy;
        logic          pop;

        assign pop = (occ != 2'd0) && m_tready[p];

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                occ <= 2'd0;
                rdy <= 1'b1;
            end else if (push[p] && !pop) begin
                occ <= occ + 2'd1;
                rdy <= (occ == 2'd0);
            end else if (pop && !push[p]) begin
                occ <= occ - 2'd1;
                rdy <= 1'b1;
            end
        end

        always_ff @(posedge sys_clk) begin
            if (pop && (occ == 2'd2))
                slot0 <= slot1;
            else if (push[p] && ((occ == 2'd0) || pop))
                slot0 <= in_payload;
            if (push[p] && (occ == 2'd1) && !pop)
                slot1 <= in_payload;
        end

        assign port_ready[p] = rdy;
        assign m_valid[p]    = (occ != 2'd0);
        assign m_payload[p]  = slot0;
    end

    assign {to_cpu_tdata, to_cpu_tkeep, to_cpu_tlast, to_cpu_tuser_bypass_all,
            to_cpu_tuser_bypass_stage, to_cpu_tuser_src, to_cpu_tuser_dst} = m_payload[0];
    assign {to_eth_1_tdata, to_eth_1_tkeep, to_eth_1_tlast, to_eth_1_tuser_bypass_all,
            to_eth_1_tuser_bypass_stage, to_eth_1_tuser_src, to_eth_1_tuser_dst} = m_payload[1];
    assign {to_eth_2_tdata, to_eth_2_tkeep, to_eth_2_tlast, to_eth_2_tuser_bypass_all,
            to_eth_2_tuser_bypass_stage, to_eth_2_tuser_src, to_eth_2_tuser_dst} = m_payload[2];
    assign {to_eth_3_tdata, to_eth_3_tkeep, to_eth_3_tlast, to_eth_3_tuser_bypass_all,
            to_eth_3_tuser_bypass_stage, to_eth_3_tuser_src, to_eth_3_tuser_dst} = m_payload[3];
    assign {to_eth_4_tdata, to_eth_4_tkeep, to_eth_4_tlast, to_eth_4_tuser_bypass_all,
            to_eth_4_tuser_bypass_stage, to_eth_4_tuser_src, to_eth_4_tuser_dst} = m_payload[4];

    assign to_cpu_tvalid   = m_valid[0];
    assign to_eth_1_tvalid = m_valid[1];
    assign to_eth_2_tvalid = m_valid[2];
    assign to_eth_3_tvalid = m_valid[3];
    assign to_eth_4_tvalid = m_valid[4];

    assign is_idle = (state_q == ST_IDLE) && (m_valid == '0);

endmodule

// File: tb/tb_dpe_demultiplexer.sv
// Directed bench for dpe_demultiplexer: a routing/drop vector table plus hand-written
// back-pressure, pause, saturation and mid-packet reset sequences.
module tb_dpe_demultiplexer;

    localparam int DW = 128;
    localparam int KW = DW/8;
    localparam int CW = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          pause;
    logic          is_idle;
    logic [CW-1:0] drop_cnt;

    logic [DW-1:0] from_dpe_tdata;
    logic [KW-1:0] from_dpe_tkeep;
    logic          from_dpe_tlast, from_dpe_tuser_bypass_all, from_dpe_tuser_bypass_stage;
    logic [2:0]    from_dpe_tuser_src, from_dpe_tuser_dst;
    logic          from_dpe_tvalid, from_dpe_tready;

    logic [DW-1:0] port_tdata [5];
    logic [KW-1:0] port_tkeep [5];
    logic          port_tlast [5];
    logic          port_ball [5];
    logic          port_bstage [5];
    logic [2:0]    port_src [5];
    logic [2:0]    port_dst [5];
    logic          port_tvalid [5];
    logic          port_tready [5];

    typedef struct {
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [7:0]  tag;
        logic        last;
        int          exp_port;
        logic [15:0] exp_drop;
    } vec_t;

    typedef struct {
        int          port;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic        last;
        logic        ball;
        logic        bstage;
        logic [2:0]  src;
        logic [2:0]  dst;
        int          cyc;
    } cap_t;

    vec_t tbl [23];
    int   acc [23];
    cap_t cap_q [$];
    int   cycle = 0;
    int   accepted_beats = 0;
    int   checks_total = 0;
    int   checks_passed = 0;

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cycle <= cycle + 1;

    dpe_demultiplexer #(.DATA_WIDTH(DW), .DROP_CNT_W(CW)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pause(pause), .is_idle(is_idle), .drop_cnt(drop_cnt),
        .from_dpe_tdata(from_dpe_tdata), .from_dpe_tkeep(from_dpe_tkeep), .from_dpe_tlast(from_dpe_tlast),
        .from_dpe_tuser_bypass_all(from_dpe_tuser_bypass_all), .from_dpe_tuser_bypass_stage(from_dpe_tuser_bypass_stage),
        .from_dpe_tuser_src(from_dpe_tuser_src), .from_dpe_tuser_dst(from_dpe_tuser_dst),
        .from_dpe_tvalid(from_dpe_tvalid), .from_dpe_tready(from_dpe_tready),
        .to_cpu_tdata(port_tdata[0]), .to_cpu_tkeep(port_tkeep[0]), .to_cpu_tlast(port_tlast[0]),
        .to_cpu_tuser_bypass_all(port_ball[0]), .to_cpu_tuser_bypass_stage(port_bstage[0]),
        .to_cpu_tuser_src(port_src[0]), .to_cpu_tuser_dst(port_dst[0]),
        .to_cpu_tvalid(port_tvalid[0]), .to_cpu_tready(port_tready[0]),
        .to_eth_1_tdata(port_tdata[1]), .to_eth_1_tkeep(port_tkeep[1]), .to_eth_1_tlast(port_tlast[1]),
        .to_eth_1_tuser_bypass_all(port_ball[1]), .to_eth_1_tuser_bypass_stage(port_bstage[1]),
        .to_eth_1_tuser_src(port_src[1]), .to_eth_1_tuser_dst(port_dst[1]),
        .to_eth_1_tvalid(port_tvalid[1]), .to_eth_1_tready(port_tready[1]),
        .to_eth_2_tdata(port_tdata[2]), .to_eth_2_tkeep(port_tkeep[2]), .to_eth_2_tlast(port_tlast[2]),
        .to_eth_2_tuser_bypass_all(port_ball[2]), .to_eth_2_tuser_bypass_stage(port_bstage[2]),
        .to_eth_2_tuser_src(port_src[2]), .to_eth_2_tuser_dst(port_dst[2]),
        .to_eth_2_tvalid(port_tvalid[2]), .to_eth_2_tready(port_tready[2]),
        .to_eth_3_tdata(port_tdata[3]), .to_eth_3_tkeep(port_tkeep[3]), .to_eth_3_tlast(port_tlast[3]),
        .to_eth_3_tuser_bypass_all(port_ball[3]), .to_eth_3_tuser_bypass_stage(port_bstage[3]),
        .to_eth_3_tuser_src(port_src[3]), .to_eth_3_tuser_dst(port_dst[3]),
        .to_eth_3_tvalid(port_tvalid[3]), .to_eth_3_tready(port_tready[3]),
        .to_eth_4_tdata(port_tdata[4]), .to_eth_4_tkeep(port_tkeep[4]), .to_eth_4_tlast(port_tlast[4]),
        .to_eth_4_tuser_bypass_all(port_ball[4]), .to_eth_4_tuser_bypass_stage(port_bstage[4]),
        .to_eth_4_tuser_src(port_src[4]), .to_eth_4_tuser_dst(port_dst[4]),
        .to_eth_4_tvalid(port_tvalid[4]), .to_eth_4_tready(port_tready[4])
    );

    // Beats are recorded on the falling edge when they will transfer on the next rising edge.
    always @(negedge sys_clk) begin
        for (int p = 0; p < 5; p++) begin
            if (port_tvalid[p] && port_tready[p]) begin
                cap_t c;
                c.port = p;            c.data = port_tdata[p]; c.keep = port_tkeep[p];
                c.last = port_tlast[p]; c.ball = port_ball[p];  c.bstage = port_bstage[p];
                c.src = port_src[p];   c.dst = port_dst[p];    c.cyc = cycle;
                cap_q.push_back(c);
            end
        end
    end

    function automatic logic [DW-1:0] mk_data(input logic [7:0] tag);
        return {64'h0123_4567_89AB_CDEF, 56'h0, tag};
    endfunction

    function automatic logic [KW-1:0] mk_keep(input logic [7:0] tag);
        return {tag, ~tag};
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks_total++;
        if (actual === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic apply_stimulus(input logic [2:0] dst, input logic [2:0] src, input logic [7:0] tag,
                                  input logic last, output int acc_cyc);
        int waited = 0;
        from_dpe_tdata              = mk_data(tag);
        from_dpe_tkeep              = mk_keep(tag);
        from_dpe_tlast              = last;
        from_dpe_tuser_bypass_all   = tag[0];
        from_dpe_tuser_bypass_stage = tag[1];
        from_dpe_tuser_src          = src;
        from_dpe_tuser_dst          = dst;
        from_dpe_tvalid             = 1'b1;
        @(negedge sys_clk);
        while (!from_dpe_tready && waited < 50) begin
            @(negedge sys_clk);
            waited++;
        end
        check_output("beat_accept", from_dpe_tready, 1'b1);
        acc_cyc = -1;
        if (from_dpe_tready) begin
            @(posedge sys_clk);
            #1;
            accepted_beats++;
            acc_cyc = cycle;
        end
        from_dpe_tvalid = 1'b0;
    endtask

    task automatic drop_beats(input int n);
        from_dpe_tuser_dst = 3'd7;
        from_dpe_tlast     = 1'b1;
        from_dpe_tvalid    = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            if (!from_dpe_tready) begin
                check_output("drop_accept", from_dpe_tready, 1'b1);
                break;
            end
            @(posedge sys_clk);
        end
        #1;
        from_dpe_tvalid = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic [2:0] dst, input logic [2:0] src, input logic [7:0] tag,
                           input logic last, input int port, input logic [15:0] drop);
        tbl[i].dst = dst; tbl[i].src = src; tbl[i].tag = tag; tbl[i].last = last;
        tbl[i].exp_port = port; tbl[i].exp_drop = drop;
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int c;
        int cnt [5];
        int exp_cnt [5];
        int base;
        int n;

        exp_cnt = '{3, 3, 4, 6, 3};
        sys_rst_n = 1'b0;
        pause = 1'b1;
        from_dpe_tdata = '0; from_dpe_tkeep = '0; from_dpe_tlast = 1'b0;
        from_dpe_tuser_bypass_all = 1'b0; from_dpe_tuser_bypass_stage = 1'b0;
        from_dpe_tuser_src = 3'd0; from_dpe_tuser_dst = 3'd0; from_dpe_tvalid = 1'b0;
        for (int p = 0; p < 5; p++) port_tready[p] = 1'b1;

        // Reset and unpause
        repeat (2) @(posedge sys_clk);
        #1;
        check_output("reset_is_idle", is_idle, 1'b1);
        check_output("reset_tready", from_dpe_tready, 1'b0);
        check_output("reset_drop_cnt", drop_cnt, 16'h0);
        for (int p = 0; p < 5; p++) check_output($sformatf("reset_tvalid%0d", p), port_tvalid[p], 1'b0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check_output("paused_is_idle", is_idle, 1'b1);
        check_output("paused_tready", from_dpe_tready, 1'b0);
        pause = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check_output("unpause_tready", from_dpe_tready, 1'b1);
        check_output("unpause_is_idle", is_idle, 1'b0);

        // Routing, drop and mid-packet destination change, all outputs ready
        set_vec(0, 3'd0, 3'd1, 8'h01, 1'b0, 0, 16'd0);
        set_vec(1, 3'd0, 3'd1, 8'h02, 1'b0, 0, 16'd0);
        set_vec(2, 3'd0, 3'd1, 8'h03, 1'b1, 0, 16'd0);
        set_vec(3, 3'd1, 3'd2, 8'h04, 1'b0, 1, 16'd0);
        set_vec(4, 3'd1, 3'd2, 8'h05, 1'b0, 1, 16'd0);
        set_vec(5, 3'd1, 3'd2, 8'h06, 1'b1, 1, 16'd0);
        set_vec(6, 3'd2, 3'd3, 8'h07, 1'b0, 2, 16'd0);
        set_vec(7, 3'd2, 3'd3, 8'h08, 1'b0, 2, 16'd0);
        set_vec(8, 3'd2, 3'd3, 8'h09, 1'b1, 2, 16'd0);
        set_vec(9, 3'd3, 3'd4, 8'h0A, 1'b0, 3, 16'd0);
        set_vec(10, 3'd3, 3'd4, 8'h0B, 1'b0, 3, 16'd0);
        set_vec(11, 3'd3, 3'd4, 8'h0C, 1'b1, 3, 16'd0);
        set_vec(12, 3'd4, 3'd5, 8'h0D, 1'b0, 4, 16'd0);
        set_vec(13, 3'd4, 3'd5, 8'h0E, 1'b0, 4, 16'd0);
        set_vec(14, 3'd4, 3'd5, 8'h0F, 1'b1, 4, 16'd0);
        set_vec(15, 3'd6, 3'd6, 8'h10, 1'b0, 5, 16'd0);
        set_vec(16, 3'd5, 3'd6, 8'h11, 1'b0, 5, 16'd0);
        set_vec(17, 3'd7, 3'd6, 8'h12, 1'b0, 5, 16'd0);
        set_vec(18, 3'd6, 3'd6, 8'h13, 1'b1, 5, 16'd1);
        set_vec(19, 3'd2, 3'd7, 8'h14, 1'b1, 2, 16'd1);
        set_vec(20, 3'd3, 3'd0, 8'h15, 1'b0, 3, 16'd1);
        set_vec(21, 3'd1, 3'd0, 8'h16, 1'b0, 3, 16'd1);
        set_vec(22, 3'd0, 3'd0, 8'h17, 1'b1, 3, 16'd1);

        cap_q.delete();
        for (int i = 0; i < 23; i++) begin
            apply_stimulus(tbl[i].dst, tbl[i].src, tbl[i].tag, tbl[i].last, acc[i]);
            check_output($sformatf("drop_cnt_v%0d", i), drop_cnt, tbl[i].exp_drop);
        end
        check_output("routing_no_bubble", acc[14] - acc[0], 14);
        check_output("table_no_bubble", acc[22] - acc[0], 22);
        repeat (3) @(posedge sys_clk);
        #1;
        for (int p = 0; p < 5; p++) cnt[p] = 0;
        foreach (cap_q[j]) cnt[cap_q[j].port]++;
        for (int p = 0; p < 5; p++) check_output($sformatf("beat_count_port%0d", p), cnt[p], exp_cnt[p]);
        k = 0;
        for (int i = 0; i < 23; i++) begin
            if (tbl[i].exp_port != 5) begin
                if (k < cap_q.size()) begin
                    check_output($sformatf("port_v%0d", i), cap_q[k].port, tbl[i].exp_port);
                    check_output($sformatf("tdata_v%0d", i), cap_q[k].data, mk_data(tbl[i].tag));
                    check_output($sformatf("tkeep_v%0d", i), cap_q[k].keep, mk_keep(tbl[i].tag));
                    check_output($sformatf("tlast_v%0d", i), cap_q[k].last, tbl[i].last);
                    check_output($sformatf("tuser_src_v%0d", i), cap_q[k].src, tbl[i].src);
                    check_output($sformatf("tuser_dst_v%0d", i), cap_q[k].dst, tbl[i].dst);
                    check_output($sformatf("bypass_v%0d", i), {cap_q[k].ball, cap_q[k].bstage}, {tbl[i].tag[0], tbl[i].tag[1]});
                    check_output($sformatf("latency_v%0d", i), cap_q[k].cyc, acc[i]);
                end else begin
                    check_output($sformatf("missing_v%0d", i), cap_q.size(), k + 1);
                end
                k++;
            end
        end

        // Back-pressure on ETH_1 while CPU drains independently
        cap_q.delete();
        port_tready[0] = 1'b0;
        port_tready[1] = 1'b0;
        base = accepted_beats;
        fork
            begin
                int dc;
                apply_stimulus(3'd0, 3'd1, 8'h20, 1'b0, dc);
                apply_stimulus(3'd0, 3'd1, 8'h21, 1'b1, dc);
                for (int b = 0; b < 6; b++)
                    apply_stimulus(3'd1, 3'd2, 8'(8'h30 + b), (b == 5), dc);
            end
            begin
                repeat (6) @(posedge sys_clk);
                #1;
                check_output("bp_accepted", accepted_beats - base, 4);
                check_output("bp_tready_low", from_dpe_tready, 1'b0);
                check_output("bp_eth1_tvalid", port_tvalid[1], 1'b1);
                check_output("bp_eth1_head", port_tdata[1], mk_data(8'h30));
                check_output("bp_no_output", cap_q.size(), 0);
                port_tready[0] = 1'b1;
                repeat (3) @(posedge sys_clk);
                #1;
                check_output("bp_cpu_drained", cap_q.size(), 2);
                check_output("bp_still_stalled", accepted_beats - base, 4);
                check_output("bp_tready_still_low", from_dpe_tready, 1'b0);
                port_tready[1] = 1'b1;
            end
        join
        repeat (3) @(posedge sys_clk);
        #1;
        n = 0;
        foreach (cap_q[j]) begin
            if (cap_q[j].port == 1) begin
                check_output($sformatf("bp_order%0d", n), cap_q[j].data, mk_data(8'(8'h30 + n)));
                check_output($sformatf("bp_tlast%0d", n), cap_q[j].last, (n == 5));
                n++;
            end
        end
        check_output("bp_eth1_count", n, 6);

        // Pause raised during beat 2 of a 5-beat packet to ETH_4
        cap_q.delete();
        apply_stimulus(3'd4, 3'd3, 8'h40, 1'b0, c);
        pause = 1'b1;
        for (int b = 1; b < 5; b++)
            apply_stimulus(3'd4, 3'd3, 8'(8'h40 + b), (b == 4), c);
        check_output("pause_tready_low", from_dpe_tready, 1'b0);
        check_output("pause_tail_pending", is_idle, 1'b0);
        check_output("pause_tail_valid", port_tvalid[4], 1'b1);
        @(posedge sys_clk); #1;
        check_output("pause_is_idle", is_idle, 1'b1);
        check_output("pause_beats", cap_q.size(), 5);
        if (cap_q.size() == 5) begin
            check_output("pause_last_data", cap_q[4].data, mk_data(8'h44));
            check_output("pause_last_tlast", cap_q[4].last, 1'b1);
        end
        from_dpe_tuser_dst = 3'd0;
        from_dpe_tvalid = 1'b1;
        @(negedge sys_clk);
        check_output("idle_holds_tready", from_dpe_tready, 1'b0);
        @(posedge sys_clk); #1;
        from_dpe_tvalid = 1'b0;
        pause = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;

        // Drop counter saturation (count is 1 from the earlier dropped packet)
        cap_q.delete();
        drop_beats(65533);
        check_output("drop_cnt_fffe", drop_cnt, 16'hFFFE);
        drop_beats(1);
        check_output("drop_cnt_ffff", drop_cnt, 16'hFFFF);
        drop_beats(1);
        check_output("drop_cnt_saturated", drop_cnt, 16'hFFFF);
        check_output("drop_no_output", cap_q.size(), 0);

        // Reset in the middle of a buffered packet
        port_tready[0] = 1'b0;
        apply_stimulus(3'd0, 3'd1, 8'h50, 1'b0, c);
        apply_stimulus(3'd0, 3'd1, 8'h51, 1'b0, c);
        check_output("midrst_buffered", port_tvalid[0], 1'b1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_output("midrst_tvalid", port_tvalid[0], 1'b0);
        check_output("midrst_is_idle", is_idle, 1'b1);
        check_output("midrst_drop_cnt", drop_cnt, 16'h0);
        check_output("midrst_tready", from_dpe_tready, 1'b0);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
